// File: rtl/stim_seq_pkg.sv
// Shared types for the stimulus sequencer: FSM state encoding and Mode values.
package stim_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_PH   = 3'd1,
        START_PH = 3'd2,
        WAIT_PH  = 3'd3,
        DONE_ST  = 3'd4
    } state_e;

    localparam logic MODE_BCAST = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stim_sequencer_phase_counter.sv
// Loadable down-counter with zero flag, used for phase length and pulse count.
// Latency: load/decrement visible the cycle after the control; no backpressure.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: DUT reset window, then a train of Start pulses with idle gaps.
// Latency: Go sampled at edge N shows on the outputs from edge N+1; all outputs registered.
// No backpressure; Go is ignored while busy. STIM_SEQ_ABORT_EN adds abort_i/aborted_o.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int CHANNELS = 2,
    parameter int CYC_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                go_i,
    input  logic [CNT_W-1:0]    rst_len_i,
    input  logic [CNT_W-1:0]    start_len_i,
    input  logic [CNT_W-1:0]    idle_len_i,
    input  logic [CNT_W-1:0]    repeat_i,
    input  logic                mode_i,
`ifdef STIM_SEQ_ABORT_EN
    input  logic                abort_i,
    output logic                aborted_o,
`endif
    output logic                dut_reset_o,
    output logic [CHANNELS-1:0] start_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CYC_W-1:0]    cycle_count_o
);

    localparam int CH_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      start_len_q, idle_len_q, repeat_q;
    logic                  mode_q, mode_d;
    logic [CH_IDX_W-1:0]   ch_q, ch_d;
    logic                  go_acc;

    logic                  ph_load, ph_en, ph_zero;
    logic [CNT_W-1:0]      ph_val, ph_cnt_unused;
    logic                  pc_load, pc_en, pc_zero;
    logic [CNT_W-1:0]      pc_cnt;

    logic                  dut_reset_q, busy_q, done_q;
    logic [CHANNELS-1:0]   start_q;
    logic [CYC_W-1:0]      cyc_q;
`ifdef STIM_SEQ_ABORT_EN
    logic                  aborted_q;
    logic                  abort_hit;
`endif

    // A zero StartLen still yields a one-cycle pulse.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    function automatic logic [CH_IDX_W-1:0] ch_next(input logic [CH_IDX_W-1:0] ch);
        if (CHANNELS == 1 || ch == CH_IDX_W'(CHANNELS - 1)) return '0;
        return ch + 1'b1;
    endfunction

    function automatic logic [CHANNELS-1:0] pattern(input logic [CH_IDX_W-1:0] ch, input logic mode);
        if (mode == MODE_RR && CHANNELS > 1) return CHANNELS'(1) << ch;
        return '1;
    endfunction

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .en_i       (ph_en),
        .cnt_o      (ph_cnt_unused),
        .zero_o     (ph_zero)
    );

    phase_counter #(.CNT_W(CNT_W)) u_pulse (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (pc_load),
        .load_val_i (repeat_i),
        .en_i       (pc_en),
        .cnt_o      (pc_cnt),
        .zero_o     (pc_zero)
    );

    assign go_acc = (state_q == IDLE) && go_i;

    always_comb begin
        state_d = state_q;
        ph_load = 1'b0;
        ph_val  = '0;
        ph_en   = 1'b0;
        pc_load = 1'b0;
        pc_en   = 1'b0;
        ch_d    = ch_q;
        mode_d  = go_acc ? mode_i : mode_q;
        case (state_q)
            IDLE: if (go_i) begin
                pc_load = 1'b1;
                ch_d    = '0;
                if (rst_len_i != '0) begin
                    state_d = RST_PH;
                    ph_load = 1'b1;
                    ph_val  = rst_len_i - 1'b1;
                end else if (repeat_i != '0) begin
                    state_d = START_PH;
                    ph_load = 1'b1;
                    ph_val  = last_cnt(start_len_i);
                end else begin
                    state_d = DONE_ST;
                end
            end
            RST_PH: if (ph_zero) begin
                if (repeat_q != '0) begin
                    state_d = START_PH;
                    ph_load = 1'b1;
                    ph_val  = last_cnt(start_len_q);
                end else begin
                    state_d = DONE_ST;
                end
            end else begin
                ph_en = 1'b1;
            end
            // The pulse counter still holds the pre-decrement value here, so 1 means last pulse.
            START_PH: if (ph_zero) begin
                pc_en = 1'b1;
                ch_d  = ch_next(ch_q);
                if (idle_len_q != '0) begin
                    state_d = WAIT_PH;
                    ph_load = 1'b1;
                    ph_val  = idle_len_q - 1'b1;
                end else if (pc_cnt != CNT_W'(1)) begin
                    state_d = START_PH;
                    ph_load = 1'b1;
                    ph_val  = last_cnt(start_len_q);
                end else begin
                    state_d = DONE_ST;
                end
            end else begin
                ph_en = 1'b1;
            end
            WAIT_PH: if (ph_zero) begin
                if (!pc_zero) begin
                    state_d = START_PH;
                    ph_load = 1'b1;
                    ph_val  = last_cnt(start_len_q);
                end else begin
                    state_d = DONE_ST;
                end
            end else begin
                ph_en = 1'b1;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef STIM_SEQ_ABORT_EN
        if (abort_hit) begin
            state_d = IDLE;
            ph_load = 1'b0;
            ph_en   = 1'b0;
            pc_en   = 1'b0;
        end
`endif
    end

`ifdef STIM_SEQ_ABORT_EN
    assign abort_hit = abort_i && (state_q != IDLE);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            start_len_q <= '0;
            idle_len_q  <= '0;
            repeat_q    <= '0;
            mode_q      <= MODE_BCAST;
            ch_q        <= '0;
            dut_reset_q <= 1'b0;
            start_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cyc_q       <= '0;
`ifdef STIM_SEQ_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mode_q  <= mode_d;
            if (go_acc) begin
                start_len_q <= start_len_i;
                idle_len_q  <= idle_len_i;
                repeat_q    <= repeat_i;
            end
            dut_reset_q <= (state_d == RST_PH);
            start_q     <= (state_d == START_PH) ? pattern(ch_d, mode_d) : '0;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE_ST);
            if (go_acc) begin
                cyc_q <= '0;
            end else if ((state_q != IDLE) && (cyc_q != {CYC_W{1'b1}})) begin
                cyc_q <= cyc_q + 1'b1;
            end
`ifdef STIM_SEQ_ABORT_EN
            if (go_acc) begin
                aborted_q <= 1'b0;
            end else if (abort_hit) begin
                aborted_q <= 1'b1;
            end
`endif
        end
    end

    assign dut_reset_o   = dut_reset_q;
    assign start_o       = start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_count_o = cyc_q;
`ifdef STIM_SEQ_ABORT_EN
    assign aborted_o     = aborted_q;
`endif

endmodule
